// File: rtl/cfg_info_responder.sv
// Read-only configuration info responder with a 2-entry in-order response FIFO.
// Ports: clk_i/rst_i (sync active-high), req_valid_i/req_ready_o/req_addr_i/req_id_i,
//   rsp_valid_o/rsp_ready_i/rsp_data_o/rsp_id_o/rsp_err_o. Optional access counter
//   at word 0x0F selected by macro CFG_INFO_ACCESS_CNT_EN.
module cfg_info_responder #(
  parameter int unsigned XLEN              = 64,
  parameter int unsigned ID_WIDTH          = 4,
  parameter int unsigned ICACHE_BYTE_SIZE  = 16384,
  parameter int unsigned ICACHE_SET_ASSOC  = 4,
  parameter int unsigned ICACHE_LINE_WIDTH = 128,
  parameter int unsigned DCACHE_BYTE_SIZE  = 32768,
  parameter int unsigned DCACHE_SET_ASSOC  = 8,
  parameter int unsigned DCACHE_LINE_WIDTH = 128,
  parameter int unsigned NR_SB_ENTRIES     = 8,
  parameter int unsigned NR_PMP_ENTRIES    = 8,
  parameter logic        RVA               = 1'b1,
  parameter logic        RVC               = 1'b1,
  parameter logic        RVF               = 1'b1,
  parameter logic        RVS               = 1'b1,
  parameter logic        RVU               = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [7:0]          req_addr_i,
  input  logic [ID_WIDTH-1:0] req_id_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [XLEN-1:0]     rsp_data_o,
  output logic [ID_WIDTH-1:0] rsp_id_o,
  output logic                rsp_err_o
);

  // D mirrors F; I and M are always present.
  localparam logic [31:0] MISA = {
    11'b0, RVU, 1'b0, RVS, 5'b0, 1'b1,
    3'b0, 1'b1, 2'b0, RVF, 1'b0, RVF,
    RVC, 1'b0, RVA
  };

  logic [1:0]          count;
  logic                wr_ptr;
  logic                rd_ptr;
  logic [XLEN-1:0]     data_q [2];
  logic [ID_WIDTH-1:0] id_q   [2];
  logic                err_q  [2];

  logic                push;
  logic                pop;
  logic [XLEN-1:0]     rd_data;
  logic                rd_err;

`ifdef CFG_INFO_ACCESS_CNT_EN
  logic [31:0] acc_cnt;
`endif

  // Ready depends only on registered occupancy.
  assign req_ready_o = (count != 2'd2);
  assign rsp_valid_o = (count != 2'd0);
  assign rsp_data_o  = data_q[rd_ptr];
  assign rsp_id_o    = id_q[rd_ptr];
  assign rsp_err_o   = err_q[rd_ptr];

  assign push = req_valid_i & req_ready_o;
  assign pop  = rsp_valid_o & rsp_ready_i;

  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    unique case (1'b1)
      (req_addr_i == 8'h00): rd_data = XLEN'(32'h4356_4136);
      (req_addr_i == 8'h01): rd_data = XLEN'(XLEN);
      (req_addr_i == 8'h02): rd_data = XLEN'(ICACHE_BYTE_SIZE);
      (req_addr_i == 8'h03): rd_data = XLEN'(ICACHE_SET_ASSOC);
      (req_addr_i == 8'h04): rd_data = XLEN'(ICACHE_LINE_WIDTH);
      (req_addr_i == 8'h05): rd_data = XLEN'(DCACHE_BYTE_SIZE);
      (req_addr_i == 8'h06): rd_data = XLEN'(DCACHE_SET_ASSOC);
      (req_addr_i == 8'h07): rd_data = XLEN'(DCACHE_LINE_WIDTH);
      (req_addr_i == 8'h08): rd_data = XLEN'(NR_SB_ENTRIES);
      (req_addr_i == 8'h09): rd_data = XLEN'(NR_PMP_ENTRIES);
      (req_addr_i == 8'h0A): rd_data = XLEN'(MISA);
`ifdef CFG_INFO_ACCESS_CNT_EN
      // Pre-increment value: the read itself is not counted yet.
      (req_addr_i == 8'h0F): rd_data = XLEN'(acc_cnt);
`endif
      default:               rd_err  = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        data_q[i] <= '0;
        id_q[i]   <= '0;
        err_q[i]  <= 1'b0;
      end
    end else begin
      if (push) begin
        data_q[wr_ptr] <= rd_data;
        id_q[wr_ptr]   <= req_id_i;
        err_q[wr_ptr]  <= rd_err;
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

`ifdef CFG_INFO_ACCESS_CNT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_cnt <= 32'd0;
    end else if (push) begin
      acc_cnt <= acc_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cfg_info_responder.sv
// Self-checking bench for cfg_info_responder: table-driven single reads
// plus hand-written backpressure, throughput, counter and reset sequences.
module tb_cfg_info_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_addr;
  logic [3:0]  req_id;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_data;
  logic [3:0]  rsp_id;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cfg_info_responder dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_addr_i  (req_addr),
    .req_id_i    (req_id),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_data_o  (rsp_data),
    .rsp_id_o    (rsp_id),
    .rsp_err_o   (rsp_err)
  );

  typedef struct {
    logic [7:0]  addr;
    logic [3:0]  id;
    logic [63:0] data;
    logic        err;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic single(input vec_t v);
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_addr  = v.addr;
    req_id    = v.id;
    chk($sformatf("rdy_%0h", v.addr), req_ready, 1);
    tick;
    req_valid = 1'b0;
    chk($sformatf("vld_%0h", v.addr), rsp_valid, 1);
    chk($sformatf("data_%0h", v.addr), rsp_data, v.data);
    chk($sformatf("id_%0h", v.addr), rsp_id, v.id);
    chk($sformatf("err_%0h", v.addr), rsp_err, v.err);
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    chk($sformatf("empty_%0h", v.addr), rsp_valid, 0);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick;
    rst = 1'b0;
  endtask

  initial begin
    vec_t cnt_v;
    logic [63:0] geo [0:10];
    geo[0]  = 64'h4356_4136;
    geo[1]  = 64'd64;
    geo[2]  = 64'd16384;
    geo[3]  = 64'd4;
    geo[4]  = 64'd128;
    geo[5]  = 64'd32768;
    geo[6]  = 64'd8;
    geo[7]  = 64'd128;
    geo[8]  = 64'd8;
    geo[9]  = 64'd8;
    geo[10] = 64'h0014_112D;

    vecs[0]  = '{8'h00, 4'h3, 64'h4356_4136, 1'b0};
    vecs[1]  = '{8'h0A, 4'h1, 64'h0014_112D, 1'b0};
    vecs[2]  = '{8'h05, 4'h2, 64'd32768,     1'b0};
    vecs[3]  = '{8'h09, 4'h4, 64'd8,         1'b0};
    vecs[4]  = '{8'h01, 4'h5, 64'd64,        1'b0};
    vecs[5]  = '{8'h02, 4'h6, 64'd16384,     1'b0};
    vecs[6]  = '{8'h03, 4'h7, 64'd4,         1'b0};
    vecs[7]  = '{8'h04, 4'h8, 64'd128,       1'b0};
    vecs[8]  = '{8'h06, 4'h9, 64'd8,         1'b0};
    vecs[9]  = '{8'h07, 4'hA, 64'd128,       1'b0};
    vecs[10] = '{8'h08, 4'hB, 64'd8,         1'b0};
    vecs[11] = '{8'h20, 4'hC, 64'd0,         1'b1};
    vecs[12] = '{8'h0B, 4'hD, 64'd0,         1'b1};
    vecs[13] = '{8'h0E, 4'hE, 64'd0,         1'b1};
    vecs[14] = '{8'hFF, 4'hF, 64'd0,         1'b1};

    rst       = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    req_id    = '0;
    rsp_ready = 1'b0;
    tick;
    tick;
    rst = 1'b0;
    chk("rst_valid", rsp_valid, 0);
    chk("rst_ready", req_ready, 1);
    chk("rst_data", rsp_data, 0);
    chk("rst_id", rsp_id, 0);
    chk("rst_err", rsp_err, 0);

    for (int i = 0; i < 15; i++) single(vecs[i]);

    // Backpressure: third request must wait while FIFO is full.
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_addr  = 8'h01;
    req_id    = 4'h1;
    tick;
    chk("bp_data1", rsp_data, 64'd64);
    chk("bp_rdy1", req_ready, 1);
    req_addr = 8'h02;
    req_id   = 4'h2;
    tick;
    chk("bp_full", req_ready, 0);
    req_addr = 8'h03;
    req_id   = 4'h3;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("bp_hold_rdy", req_ready, 0);
      chk("bp_hold_data", rsp_data, 64'd64);
      chk("bp_hold_id", rsp_id, 4'h1);
    end
    rsp_ready = 1'b1;
    tick;
    chk("bp_data2", rsp_data, 64'd16384);
    chk("bp_id2", rsp_id, 4'h2);
    chk("bp_rdy_back", req_ready, 1);
    tick;
    req_valid = 1'b0;
    chk("bp_data3", rsp_data, 64'd4);
    chk("bp_id3", rsp_id, 4'h3);
    chk("bp_vld3", rsp_valid, 1);
    tick;
    chk("bp_drained", rsp_valid, 0);

    // One response per cycle with simultaneous push/pop.
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_addr  = 8'h01;
    req_id    = 4'h1;
    tick;
    for (int i = 2; i <= 10; i++) begin
      chk("tp_vld", rsp_valid, 1);
      chk("tp_rdy", req_ready, 1);
      chk($sformatf("tp_data_%0d", i - 1), rsp_data, geo[i-1]);
      req_addr = 8'(i);
      req_id   = 4'(i);
      tick;
    end
    req_valid = 1'b0;
    chk("tp_last", rsp_data, geo[10]);
    chk("tp_last_id", rsp_id, 4'hA);
    tick;
    chk("tp_drained", rsp_valid, 0);
    rsp_ready = 1'b0;

    // Access counter.
    do_reset;
    for (int i = 0; i < 5; i++) single(vecs[i]);
`ifdef CFG_INFO_ACCESS_CNT_EN
    cnt_v = '{8'h0F, 4'h5, 64'd5, 1'b0};
`else
    cnt_v = '{8'h0F, 4'h5, 64'd0, 1'b1};
`endif
    single(cnt_v);

    // Reset discards pending responses.
    req_valid = 1'b1;
    req_addr  = 8'h02;
    req_id    = 4'h2;
    tick;
    req_addr = 8'h03;
    tick;
    req_valid = 1'b0;
    chk("pr_full", req_ready, 0);
    do_reset;
    chk("pr_valid", rsp_valid, 0);
    chk("pr_ready", req_ready, 1);
    chk("pr_data", rsp_data, 0);
`ifdef CFG_INFO_ACCESS_CNT_EN
    cnt_v = '{8'h0F, 4'h6, 64'd0, 1'b0};
`else
    cnt_v = '{8'h0F, 4'h6, 64'd0, 1'b1};
`endif
    single(cnt_v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cfg_info_responder.md
CFG_INFO_RESPONDER -- requirements
Module: cfg_info_responder

Interface
REQ-001 SHALL have parameter XLEN, default 64, response data width.
REQ-002 SHALL have parameter ID_WIDTH, default 4, request/response tag width.
REQ-003 SHALL have parameters ICACHE_BYTE_SIZE=16384, ICACHE_SET_ASSOC=4, ICACHE_LINE_WIDTH=128, DCACHE_BYTE_SIZE=32768, DCACHE_SET_ASSOC=8, DCACHE_LINE_WIDTH=128, NR_SB_ENTRIES=8, NR_PMP_ENTRIES=8, which are the reported geometry values.
REQ-004 SHALL have single-bit parameters RVA=1, RVC=1, RVF=1, RVS=1, RVU=1, which are the reported ISA options; D is reported equal to RVF.
REQ-005 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst_i  input  1  reset; synchronous and active-high.
REQ-007 req_valid_i  input  1  request valid.
REQ-008 req_ready_o  output  1  request accepted when valid and ready are both high.
REQ-009 req_addr_i  input  8  word index.
REQ-010 req_id_i  input  ID_WIDTH  tag, echoed in the response.
REQ-011 rsp_valid_o  output  1  response valid.
REQ-012 rsp_ready_i  input  1  response consumed when valid and ready are both high.
REQ-013 rsp_data_o  output  XLEN  read data.
REQ-014 rsp_id_o  output  ID_WIDTH  echoed tag.
REQ-015 rsp_err_o  output  1  unmapped address.

Function
REQ-016 SHALL hold responses in a 2-entry in-order FIFO of {data, id, err}.
REQ-017 SHALL drive req_ready_o = (FIFO count < 2), from registered state only, with no combinational path from rsp_ready_i.
REQ-018 SHALL drive rsp_valid_o = (count != 0), with the head entry on rsp_data_o, rsp_id_o and rsp_err_o.
REQ-019 SHALL present a response for an accepted request in cycle N+1; latency is exactly 1 cycle when the FIFO is empty.
REQ-020 SHALL keep rsp_* stable while rsp_valid_o=1 and rsp_ready_i=0.
REQ-021 On a simultaneous push and pop, SHALL leave count unchanged and preserve ordering; count=1 steady state SHALL sustain one response per cycle.
REQ-022 When the FIFO is full, SHALL hold req_ready_o=0, drop no request, and reassert req_ready_o in the cycle after a pop.
REQ-023 Address map SHALL be:
- 0x00: 64'h4356_4136
- 0x01: XLEN
- 0x02: ICACHE_BYTE_SIZE
- 0x03: ICACHE_SET_ASSOC
- 0x04: ICACHE_LINE_WIDTH
- 0x05: DCACHE_BYTE_SIZE
- 0x06: DCACHE_SET_ASSOC
- 0x07: DCACHE_LINE_WIDTH
- 0x08: NR_SB_ENTRIES
- 0x09: NR_PMP_ENTRIES
- 0x0A: misa-style bitmap, with A=bit0, C=bit2, D=bit3, F=bit5, I=bit8 (always 1), M=bit12 (always 1), S=bit18, U=bit20
REQ-024 All values SHALL be zero-extended to XLEN.
REQ-025 Addresses 0x0B-0x0E and 0x10-0xFF SHALL return rsp_err_o=1 with rsp_data_o=0.
REQ-026 Address 0x0F SHALL follow REQ-031 / REQ-032.

Reset
REQ-027 While rst_i=1 at a clock edge, SHALL clear the FIFO (count=0) and clear the access counter.
REQ-028 In the cycle after that edge, SHALL drive rsp_valid_o=0, req_ready_o=1, rsp_data_o=0, rsp_id_o=0, rsp_err_o=0.
REQ-029 Pending responses at reset SHALL be discarded; no request SHALL be accepted during a reset cycle.

Configuration
REQ-030 Macro CFG_INFO_ACCESS_CNT_EN SHALL select the access counter.
REQ-031 With CFG_INFO_ACCESS_CNT_EN defined:
- SHALL implement a 32-bit counter incremented on every accepted request.
- The counter SHALL wrap from 0xFFFF_FFFF to 0.
- Address 0x0F SHALL return the pre-increment value, zero-extended, with err=0.
REQ-032 Without CFG_INFO_ACCESS_CNT_EN, SHALL contain no counter logic, and address 0x0F SHALL return err=1 with data=0.

Verification
REQ-033 After reset, read 0x00 with id 0x3 -> next cycle: rsp_valid_o=1, data=64'h4356_4136, id=0x3, err=0.
REQ-034 Default parameters, read 0x0A -> data=64'h0014_112D; read 0x05 -> 32768; read 0x09 -> 8.
REQ-035 rsp_ready_i=0, requests to 0x01, 0x02, 0x03 on back-to-back cycles:
- Only 0x01 and 0x02 are accepted; req_ready_o=0 after the second.
- Data stays 64 until release; then 64, 16384, 64'd4 are returned in order.
REQ-036 Read 0x20 and read 0x0B -> err=1, data=0.
REQ-037 With macro on, 5 accepted requests then read 0x0F -> data=5; with macro off, read 0x0F -> err=1.
REQ-038 Two responses pending, assert rst_i for one cycle -> rsp_valid_o=0 and req_ready_o=1 next cycle; with macro on, a subsequent read of 0x0F returns 0.
